// File: rtl/mario_sound_mix_sched.sv
// Purpose: four-channel sound mixer with per-channel mute/attenuation; sums one sample per channel each frame, saturated to 16 bits.
// Latency: sample tick in cycle T -> O_SND_VLD/O_SND_DAT in cycle T+6; one frame every DIV clocks.
// Backpressure: none; O_SND_VLD is a one-cycle pulse, and the consumer must take it in that cycle.
//
// Ports:
//   I_CLK_12M                 sole clock
//   I_RESET                   asynchronous active-high reset; aborts any frame in progress and clears config
//   I_SND1..I_SND4            signed 16-bit channel samples ch0..ch3, sampled at the frame capture edge
//   I_CFG_WE/ADDR/DAT         config write: I_CFG_DAT = {mute, atten[2:0]} for channel I_CFG_ADDR
//   O_SND_DAT                 signed mixed sample, holds between frames
//   O_SND_VLD                 one-cycle pulse when O_SND_DAT takes a new value
//   O_CLIP                    high with O_SND_VLD when that sample was clamped
//   O_BUSY                    high while a frame is being accumulated or saturated
module mario_sound_mix_sched #(
  parameter int DIV = 250
) (
  input  logic        I_CLK_12M,
  input  logic        I_RESET,
  input  logic [15:0] I_SND1,
  input  logic [15:0] I_SND2,
  input  logic [15:0] I_SND3,
  input  logic [15:0] I_SND4,
  input  logic        I_CFG_WE,
  input  logic [1:0]  I_CFG_ADDR,
  input  logic [3:0]  I_CFG_DAT,
  output logic [15:0] O_SND_DAT,
  output logic        O_SND_VLD,
  output logic        O_CLIP,
  output logic        O_BUSY
);

  localparam logic [11:0] TICK_AT = 12'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [11:0]        tick_cnt;
  logic               tick;
  logic [1:0]         idx;
  logic signed [18:0] acc;
  logic [3:0][15:0]   snap;
  logic [3:0][3:0]    cfg;
  logic [3:0][3:0]    cfg_snap;
  logic signed [15:0] shifted;
  logic signed [18:0] term;
  logic               sat_hi;
  logic               sat_lo;

  assign tick   = (tick_cnt == TICK_AT);
  assign O_BUSY = (state != IDLE);

  // Free-running sample-rate divider; it keeps counting regardless of the FSM.
  always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
    if (I_RESET) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 12'd1;
    end
  end

  always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
    if (I_RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A tick arriving outside IDLE is simply dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = ACC;
      ACC:     if (idx == 2'd3) state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-channel term from the frozen snapshot: arithmetic shift keeps the sign,
  // then sign-extend into the 19-bit accumulator so four full-scale terms fit.
  always_comb begin
    shifted = $signed(snap[idx]) >>> cfg_snap[idx][2:0];
    term    = cfg_snap[idx][3] ? 19'sd0 : {{3{shifted[15]}}, shifted};
  end

  assign sat_hi = (acc > 19'sd32767);
  assign sat_lo = (acc < -19'sd32768);

  always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
    if (I_RESET) begin
      cfg       <= '0;
      cfg_snap  <= '0;
      snap      <= '0;
      acc       <= '0;
      idx       <= '0;
      O_SND_DAT <= '0;
      O_SND_VLD <= 1'b0;
      O_CLIP    <= 1'b0;
    end else begin
      O_SND_VLD <= 1'b0;
      O_CLIP    <= 1'b0;
      // Live config register; the capture below reads the pre-write value,
      // so a write on the capture edge only affects the following frame.
      if (I_CFG_WE) begin
        cfg[I_CFG_ADDR] <= I_CFG_DAT;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            snap     <= {I_SND4, I_SND3, I_SND2, I_SND1};
            cfg_snap <= cfg;
            acc      <= '0;
            idx      <= '0;
          end
        end
        ACC: begin
          acc <= acc + term;
          idx <= idx + 2'd1;
        end
        SAT: begin
          O_SND_VLD <= 1'b1;
          O_CLIP    <= sat_hi | sat_lo;
          if (sat_hi) begin
            O_SND_DAT <= 16'h7FFF;
          end else if (sat_lo) begin
            O_SND_DAT <= 16'h8000;
          end else begin
            O_SND_DAT <= acc[15:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
